// File: rtl/fifo_solver_if.sv
// fifo_solver_if -- beat/result bundle for the fifo_solver line filter.
//
// Handshake: there is no backpressure. The master presents one option beat
// per cycle by raising valid_op; every cycle with valid_op=1 is consumed by
// the solver. Results are qualified by the one-cycle valid_out pulse;
// put_back_to_FIFO / new_option_num hold until the next completion.
// kept_option is qualified by the one-cycle kept_valid pulse.
//
// Signals (slave = solver view):
//   valid_op, option, line_ind, options_per_line     : in  (option beat)
//   put_back_to_FIFO, new_option_num, valid_out       : out (line result)
//   assigned, assigned_known                          : out (board state)
//   kept_option, kept_valid                           : out (consistent echo)
//   busy, state_dbg                                   : out (FSM visibility)
//   contradiction                                     : out, only when
//                                                       FIFO_SOLVER_CONTRADICTION_EN
//                                                       is defined
interface fifo_solver_if #(
    parameter int SIZE = 3
);
    logic                       valid_op;
    logic [SIZE-1:0]            option;
    logic [4:0]                 line_ind;
    logic [6:0]                 options_per_line;

    logic                       put_back_to_FIFO;
    logic [6:0]                 new_option_num;
    logic [SIZE-1:0][SIZE-1:0]  assigned;
    logic [SIZE-1:0][SIZE-1:0]  assigned_known;
    logic [SIZE-1:0]            kept_option;
    logic                       kept_valid;
    logic                       busy;
    logic                       valid_out;
    logic                       state_dbg;
`ifdef FIFO_SOLVER_CONTRADICTION_EN
    logic                       contradiction;
`endif

    modport master (
        output valid_op, option, line_ind, options_per_line,
        input  put_back_to_FIFO, new_option_num, assigned, assigned_known,
               kept_option, kept_valid, busy, valid_out, state_dbg
`ifdef FIFO_SOLVER_CONTRADICTION_EN
       ,input  contradiction
`endif
    );

    modport slave (
        input  valid_op, option, line_ind, options_per_line,
        output put_back_to_FIFO, new_option_num, assigned, assigned_known,
               kept_option, kept_valid, busy, valid_out, state_dbg
`ifdef FIFO_SOLVER_CONTRADICTION_EN
       ,output contradiction
`endif
    );
endinterface

// File: rtl/fifo_solver.sv
// fifo_solver -- filters the candidate fillings of one board line against the
// currently known cells and folds the survivors back into the board.
//
// A line arrives as N option beats (N and line_ind sampled on the first beat).
// Options that contradict a known cell are dropped; for the survivors, cells
// that are 1 in every survivor become known-1 and cells that are 0 in every
// survivor become known-0. On the last beat the board update and the result
// outputs are registered, so valid_out pulses one cycle after that beat.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : fifo_solver_if.slave (beat inputs, result/board outputs)
//
// Optional feature: define FIFO_SOLVER_CONTRADICTION_EN to add the
// bus.contradiction output, pulsing with valid_out when no option survived.
//
// line_ind: 0..SIZE-1 selects row r (cell i = (r,i));
//           SIZE..2*SIZE-1 selects column c=line_ind-SIZE (cell i = (i,c)).
module fifo_solver #(
    parameter int SIZE = 3
) (
    input  logic              clk,
    input  logic              rst,
    fifo_solver_if.slave      bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        FILTER = 1'b1
    } state_t;

    state_t                     state;
    logic [4:0]                 line_q;
    logic [6:0]                 remaining_q;   // beats still expected in FILTER
    logic [SIZE-1:0]            and_acc;
    logic [SIZE-1:0]            or_acc;
    logic [6:0]                 survivors;
    logic [SIZE-1:0][SIZE-1:0]  assigned_q;
    logic [SIZE-1:0][SIZE-1:0]  known_q;
    logic                       put_back_q;
    logic [6:0]                 new_num_q;
    logic [SIZE-1:0]            kept_option_q;
    logic                       kept_valid_q;
    logic                       valid_out_q;
`ifdef FIFO_SOLVER_CONTRADICTION_EN
    logic                       contradiction_q;
`endif

    // ------------------------------------------------------------------
    // Beat qualification
    // ------------------------------------------------------------------
    logic first_beat;   // accepted beat that opens a line
    logic beat;         // any accepted beat
    logic complete;     // accepted beat that closes the line

    always_comb begin
        first_beat = (state == IDLE) && bus.valid_op &&
                     (bus.options_per_line != 7'd0) &&
                     (bus.line_ind < 5'(2 * SIZE));
        beat       = first_beat || ((state == FILTER) && bus.valid_op);
        complete   = (first_beat && (bus.options_per_line == 7'd1)) ||
                     ((state == FILTER) && bus.valid_op && (remaining_q == 7'd1));
    end

    // The line being worked on: the live input on the opening beat, the
    // latched index afterwards.
    logic [4:0] sel_line;
    int         sel_int;
    logic       sel_is_row;

    always_comb begin
        sel_line   = (state == IDLE) ? bus.line_ind : line_q;
        sel_int    = int'(sel_line);
        sel_is_row = (sel_int < SIZE);
    end

    // ------------------------------------------------------------------
    // Gather the selected line's known mask and values from the board
    // ------------------------------------------------------------------
    logic [SIZE-1:0] line_known;
    logic [SIZE-1:0] line_val;

    always_comb begin
        line_known = '0;
        line_val   = '0;
        for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE; c++) begin
                if (sel_is_row && (r == sel_int)) begin
                    line_known[c] = known_q[r][c];
                    line_val[c]   = assigned_q[r][c];
                end
                if (!sel_is_row && (c == sel_int - SIZE)) begin
                    line_known[r] = known_q[r][c];
                    line_val[r]   = assigned_q[r][c];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator update for the current beat. The opening beat starts
    // from the fresh-line values rather than the stale registers, so no
    // separate clear cycle is needed between lines.
    // ------------------------------------------------------------------
    logic            consistent;
    logic [SIZE-1:0] and_nxt;
    logic [SIZE-1:0] or_nxt;
    logic [6:0]      surv_nxt;
    logic            line_full;
    logic [6:0]      new_num_nxt;

    always_comb begin
        consistent = (((bus.option ^ line_val) & line_known) == '0);
        and_nxt    = (first_beat ? {SIZE{1'b1}} : and_acc) &
                     (consistent ? bus.option : {SIZE{1'b1}});
        or_nxt     = (first_beat ? {SIZE{1'b0}} : or_acc) |
                     (consistent ? bus.option : {SIZE{1'b0}});
        surv_nxt   = (first_beat ? 7'd0 : survivors) + (consistent ? 7'd1 : 7'd0);
        // A cell is resolved if it was known or the survivors agree on it.
        line_full  = &(line_known | and_nxt | ~or_nxt);
        new_num_nxt = ((surv_nxt == 7'd0) || line_full) ? 7'd0 : surv_nxt;
    end

    // ------------------------------------------------------------------
    // Next board on completion; unchanged when nothing survived.
    // ------------------------------------------------------------------
    logic [SIZE-1:0][SIZE-1:0] assigned_nxt;
    logic [SIZE-1:0][SIZE-1:0] known_nxt;

    always_comb begin
        assigned_nxt = assigned_q;
        known_nxt    = known_q;
        if (surv_nxt != 7'd0) begin
            for (int r = 0; r < SIZE; r++) begin
                for (int c = 0; c < SIZE; c++) begin
                    if (!known_q[r][c]) begin
                        if (sel_is_row && (r == sel_int)) begin
                            if (and_nxt[c]) begin
                                known_nxt[r][c]    = 1'b1;
                                assigned_nxt[r][c] = 1'b1;
                            end else if (!or_nxt[c]) begin
                                known_nxt[r][c]    = 1'b1;
                                assigned_nxt[r][c] = 1'b0;
                            end
                        end
                        if (!sel_is_row && (c == sel_int - SIZE)) begin
                            if (and_nxt[r]) begin
                                known_nxt[r][c]    = 1'b1;
                                assigned_nxt[r][c] = 1'b1;
                            end else if (!or_nxt[r]) begin
                                known_nxt[r][c]    = 1'b1;
                                assigned_nxt[r][c] = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            line_q          <= '0;
            remaining_q     <= '0;
            and_acc         <= {SIZE{1'b1}};
            or_acc          <= '0;
            survivors       <= '0;
            assigned_q      <= '0;
            known_q         <= '0;
            put_back_q      <= 1'b0;
            new_num_q       <= '0;
            kept_option_q   <= '0;
            kept_valid_q    <= 1'b0;
            valid_out_q     <= 1'b0;
`ifdef FIFO_SOLVER_CONTRADICTION_EN
            contradiction_q <= 1'b0;
`endif
        end else begin
            valid_out_q     <= 1'b0;
            kept_valid_q    <= 1'b0;
`ifdef FIFO_SOLVER_CONTRADICTION_EN
            contradiction_q <= 1'b0;
`endif
            if (beat) begin
                if (consistent) begin
                    kept_valid_q  <= 1'b1;
                    kept_option_q <= bus.option;
                end
                if (complete) begin
                    state       <= IDLE;
                    valid_out_q <= 1'b1;
                    assigned_q  <= assigned_nxt;
                    known_q     <= known_nxt;
                    new_num_q   <= new_num_nxt;
                    put_back_q  <= (new_num_nxt != 7'd0);
                    and_acc     <= {SIZE{1'b1}};
                    or_acc      <= '0;
                    survivors   <= '0;
                    remaining_q <= '0;
`ifdef FIFO_SOLVER_CONTRADICTION_EN
                    contradiction_q <= (surv_nxt == 7'd0);
`endif
                end else begin
                    state     <= FILTER;
                    and_acc   <= and_nxt;
                    or_acc    <= or_nxt;
                    survivors <= surv_nxt;
                    if (first_beat) begin
                        line_q      <= bus.line_ind;
                        remaining_q <= bus.options_per_line - 7'd1;
                    end else begin
                        remaining_q <= remaining_q - 7'd1;
                    end
                end
            end
        end
    end

    assign bus.assigned         = assigned_q;
    assign bus.assigned_known   = known_q;
    assign bus.put_back_to_FIFO = put_back_q;
    assign bus.new_option_num   = new_num_q;
    assign bus.kept_option      = kept_option_q;
    assign bus.kept_valid       = kept_valid_q;
    assign bus.valid_out        = valid_out_q;
    assign bus.busy             = (state == FILTER);
    assign bus.state_dbg        = state;
`ifdef FIFO_SOLVER_CONTRADICTION_EN
    assign bus.contradiction    = contradiction_q;
`endif

endmodule

// File: tb/tb_fifo_solver.sv
// tb_fifo_solver -- directed bench for fifo_solver (SIZE=3).
// Beats are driven 1 time unit after a rising edge; registered outputs are
// read 1 unit after the following edge, or on the falling edge by the monitor.
module tb_fifo_solver;

    localparam int SIZE = 3;

    logic clk;
    logic rst;

    fifo_solver_if #(.SIZE(SIZE)) bus ();

    fifo_solver #(.SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int valid_out_seen = 0;
    logic [SIZE-1:0] exp_q[$];   // expected kept_option values, in order

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid_out === 1'b1) valid_out_seen++;
            if (bus.kept_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("kept_spurious", 64'(bus.kept_option), 64'hdead);
                end else begin
                    check("kept_option", 64'(bus.kept_option), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [4:0] l, input logic [6:0] n, input logic [SIZE-1:0] opt);
        bus.line_ind         = l;
        bus.options_per_line = n;
        bus.option           = opt;
        bus.valid_op         = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_op         = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #12;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic pb, input logic [6:0] num,
                                input logic [8:0] asg, input logic [8:0] kn);
        check({tag, "_valid_out"}, 64'(bus.valid_out), 64'd1);
        check({tag, "_put_back"},  64'(bus.put_back_to_FIFO), 64'(pb));
        check({tag, "_new_num"},   64'(bus.new_option_num), 64'(num));
        check({tag, "_assigned"},  64'(bus.assigned), 64'(asg));
        check({tag, "_known"},     64'(bus.assigned_known), 64'(kn));
        check({tag, "_busy"},      64'(bus.busy), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.valid_op         = 1'b0;
        bus.option           = '0;
        bus.line_ind         = '0;
        bus.options_per_line = '0;
        do_reset();

        // Reset state
        check("rst_assigned",  64'(bus.assigned), 64'd0);
        check("rst_known",     64'(bus.assigned_known), 64'd0);
        check("rst_valid_out", 64'(bus.valid_out), 64'd0);
        check("rst_busy",      64'(bus.busy), 64'd0);
        check("rst_put_back",  64'(bus.put_back_to_FIFO), 64'd0);
        check("rst_new_num",   64'(bus.new_option_num), 64'd0);
`ifdef FIFO_SOLVER_CONTRADICTION_EN
        check("rst_contra",    64'(bus.contradiction), 64'd0);
`endif

        // Row 0, single option 101 -> fully known row
        exp_q.push_back(3'b101);
        beat(5'd0, 7'd1, 3'b101);
        check_result("row0", 1'b0, 7'd0, 9'b000_000_101, 9'b000_000_111);
        idle_cycles(1);
        check("row0_pulse_end", 64'(bus.valid_out), 64'd0);

        // Column 0 with (0,0)=1 known: 000 dropped, 101 survives
        exp_q.push_back(3'b101);
        beat(5'd3, 7'd2, 3'b000);
        check("col0_busy", 64'(bus.busy), 64'd1);
        check("col0_no_vout", 64'(bus.valid_out), 64'd0);
        beat(5'd3, 7'd2, 3'b101);
        check_result("col0", 1'b0, 7'd0, 9'b001_000_101, 9'b001_001_111);
        idle_cycles(1);

        // Fresh board; column 0 with three options and a gap after beat 1
        do_reset();
        exp_q.push_back(3'b110);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b111);
        beat(5'd3, 7'd3, 3'b110);
        idle_cycles(2);
        check("gap_busy", 64'(bus.busy), 64'd1);
        check("gap_no_vout", 64'(bus.valid_out), 64'd0);
        beat(5'd3, 7'd3, 3'b011);
        check("gap_b2_busy", 64'(bus.busy), 64'd1);
        check("gap_b2_no_vout", 64'(bus.valid_out), 64'd0);
        beat(5'd3, 7'd3, 3'b111);
        check_result("col0_multi", 1'b1, 7'd3, 9'b000_001_000, 9'b000_001_000);
        idle_cycles(2);
        check("hold_put_back", 64'(bus.put_back_to_FIFO), 64'd1);
        check("hold_new_num",  64'(bus.new_option_num), 64'd3);

        // Row 1 with (1,0)=1 known: both options have bit0=0 -> contradiction
        beat(5'd1, 7'd2, 3'b000);
        beat(5'd1, 7'd2, 3'b110);
        check_result("contra", 1'b0, 7'd0, 9'b000_001_000, 9'b000_001_000);
`ifdef FIFO_SOLVER_CONTRADICTION_EN
        check("contra_flag", 64'(bus.contradiction), 64'd1);
`endif
        idle_cycles(1);

        // Ignored beats: N=0, and an out-of-range line index
        beat(5'd0, 7'd0, 3'b111);
        check("ign_n0_busy", 64'(bus.busy), 64'd0);
        check("ign_n0_vout", 64'(bus.valid_out), 64'd0);
        beat(5'd6, 7'd1, 3'b111);
        check("ign_line_busy", 64'(bus.busy), 64'd0);
        check("ign_line_vout", 64'(bus.valid_out), 64'd0);
        check("ign_known", 64'(bus.assigned_known), 64'(9'b000_001_000));

        // Row 2 partly resolved: and=001, or=011 -> (2,0)=1, (2,2)=0
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b001);
        beat(5'd2, 7'd2, 3'b011);
        beat(5'd2, 7'd2, 3'b001);
        check_result("row2", 1'b1, 7'd2, 9'b001_001_000, 9'b101_001_000);
        idle_cycles(1);

        // Reset after beat 1 of a two-beat line
        exp_q.push_back(3'b000);
        beat(5'd0, 7'd2, 3'b000);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("abort_busy",     64'(bus.busy), 64'd0);
        check("abort_assigned", 64'(bus.assigned), 64'd0);
        check("abort_known",    64'(bus.assigned_known), 64'd0);
        check("abort_put_back", 64'(bus.put_back_to_FIFO), 64'd0);
        check("abort_new_num",  64'(bus.new_option_num), 64'd0);
        #10;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);
        check("abort_no_vout", 64'(bus.valid_out), 64'd0);

        // Next line starts fresh
        exp_q.push_back(3'b010);
        beat(5'd0, 7'd1, 3'b010);
        check_result("fresh", 1'b0, 7'd0, 9'b000_000_010, 9'b000_000_111);
        idle_cycles(2);

        check("valid_out_count", 64'(valid_out_seen), 64'd6);
        check("kept_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
